game_engine: RTL
================

Name: game_engine

Overview:
- Gameplay core that produces the win/lose verdict consumed by the top-level game FSM (`W_or_L`).
- Moves one obstacle along a fixed-length track toward the hero and turns jump-key presses into hero jumps.
- Detects collisions, keeps score, and declares win or lose.
- Also drives the hero animation variant (`var_h`) for the hero ROM and the obstacle type (`tipo_obs`) for display.

Parameters:
- TICK_DIV, 12500000: clk cycles per game step (0.25 s at 50 MHz).
- PLAY_STATE, 3'd3: value of `presente` meaning "game in progress".
- JUMP_KEY, 5'd2: keypad code that triggers a jump.
- JUMP_TICKS, 3: number of game steps the hero stays airborne.
- TRACK_LEN, 8: obstacle positions TRACK_LEN-1 down to 0; the hero sits at 0.
- WIN_SCORE, 16: number of cleared obstacles needed to win (must be ≤31).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- presente  in  3  current state of the game FSM
- keypad_pressed  in  1  level, high while a key is held
- key  in  5  keypad code, valid while keypad_pressed is high
- W_or_L  out  2  00 = no result, 01 = win, 10 = lose
- var_h  out  2  hero variant: 00 = run, 01 = jump
- tipo_obs  out  4  type of the current obstacle
- obs_pos  out  $clog2(TRACK_LEN)  obstacle position
- score  out  5  obstacles cleared in this game

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state IDLE, W_or_L=00, var_h=00, tipo_obs=0, obs_pos=TRACK_LEN-1, score=0;
  - jump_cnt=0, prescaler=0, LFSR=8'hA5, key-edge register=0.
- Reset mid-game abandons the game immediately, with no verdict.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances on every tick while in RUN. Never reaches 0.
- Tick: one-cycle pulse raised when prescaler==TICK_DIV-1; prescaler then wraps to 0. The prescaler counts only in RUN and is cleared in every other state.
- Jump request: rising edge of keypad_pressed (registered previous value) while key==JUMP_KEY.
  - A held key does not retrigger.
  - Other keys are ignored.
- States:
  - IDLE: outputs hold their reset values.
    - When presente==PLAY_STATE, go to RUN.
    - On that transition: obs_pos=TRACK_LEN-1, score=0, jump_cnt=0, prescaler=0, tipo_obs=LFSR[3:0].
  - RUN:
    - Jump request with jump_cnt==0: jump_cnt=JUMP_TICKS and var_h=01, effective from the next cycle.
    - A request while jump_cnt!=0 is ignored.
    - On tick, using the register values of that cycle:
      - obs_pos!=0: obs_pos decrements.
      - obs_pos==0 and jump_cnt!=0: obstacle cleared. score increments, obs_pos=TRACK_LEN-1, tipo_obs=LFSR[3:0]. If the new score==WIN_SCORE, go to WIN.
      - obs_pos==0 and jump_cnt==0: collision; go to LOSE.
      - In all three cases, if jump_cnt!=0 it decrements. When it reaches 0, var_h=00.
    - A jump request in the same cycle as a tick does not affect that tick's evaluation.
    - If presente leaves PLAY_STATE, go to IDLE with no verdict.
  - WIN: W_or_L=01, var_h=00. Hold until presente!=PLAY_STATE, then go to IDLE.
  - LOSE: W_or_L=10, var_h=00. Hold until presente!=PLAY_STATE, then go to IDLE.
- Timing and register rules:
  - W_or_L is registered. It becomes valid the cycle after the deciding tick.
  - On leaving WIN/LOSE, W_or_L returns to 00 one cycle after presente changes.
  - score, obs_pos and tipo_obs are frozen in WIN, LOSE and IDLE.

Optional Feature:
- Macro: GAME_SPEEDUP_EN.
- Defined: while score ≥ WIN_SCORE/2 (integer division), the tick terminal count is TICK_DIV/2-1, so the game runs twice as fast. The prescaler is cleared when the threshold is crossed so the next tick arrives a full half-period later.
- Undefined: the tick period is always TICK_DIV.

Test Plan:
All scenarios use TICK_DIV=4, TRACK_LEN=8, JUMP_TICKS=3, WIN_SCORE=4, macro undefined unless stated.
- Reset: hold rst_n=0 for 3 clks → W_or_L=00, var_h=00, obs_pos=7, score=0, tipo_obs=0.
- No jumps: set presente=3 → obs_pos reaches 0 on the 7th tick (~28 clks); the 8th tick gives W_or_L=10 the next cycle; score stays 0.
- Single clear: press JUMP_KEY when obs_pos=2 → var_h=01 next cycle. Ticks then give obs_pos 1, then 0, then 7 with score=1. var_h returns to 00 on the third tick after the press.
- Win: clear 4 consecutive obstacles → W_or_L=01 after the 4th clear. Set presente=0 → W_or_L=00 one cycle later, state IDLE.
- Key filtering:
  - Holding JUMP_KEY for 20 clks produces only one jump.
  - key=5'd7 produces no jump.
  - A second press during a jump does not extend jump_cnt.
  - A press coinciding with the collision tick still loses.
- Abort: rst_n=0 mid-RUN → reset values next cycle. With GAME_SPEEDUP_EN defined, after score=2 the ticks arrive every 2 clks.

Source files
------------

// File: rtl/game_engine.sv
// Gameplay core: obstacle track, hero jumps, collision/score and the win/lose verdict.
// Optional GAME_SPEEDUP_EN halves the tick period once half the winning score is reached.
module game_engine #(
  parameter int          TICK_DIV   = 12500000,
  parameter logic [2:0]  PLAY_STATE = 3'd3,
  parameter logic [4:0]  JUMP_KEY   = 5'd2,
  parameter int          JUMP_TICKS = 3,
  parameter int          TRACK_LEN  = 8,
  parameter int          WIN_SCORE  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   presente,
  input  logic                         keypad_pressed,
  input  logic [4:0]                   key,
  output logic [1:0]                   W_or_L,
  output logic [1:0]                   var_h,
  output logic [3:0]                   tipo_obs,
  output logic [$clog2(TRACK_LEN)-1:0] obs_pos,
  output logic [4:0]                   score
);
  localparam int PW  = $clog2(TRACK_LEN);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int JW  = $clog2(JUMP_TICKS + 1);
  localparam logic [PW-1:0] TOP = PW'(TRACK_LEN - 1);
  localparam logic [JW-1:0] JT  = JW'(JUMP_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, WON, LOST} state_t;

  state_t         state;
  logic [PSW-1:0] prescaler;
  logic [PSW-1:0] term;
  logic [JW-1:0]  jump_cnt;
  logic [7:0]     lfsr;
  logic           key_q;
  logic           tick;
  logic           jreq;
  logic           playing;
  logic [7:0]     lfsr_next;

`ifdef GAME_SPEEDUP_EN
  // The threshold is only crossed on a tick, where the prescaler wraps to 0 anyway,
  // so the first fast tick lands a full half-period after the crossing.
  assign term = (score >= 5'(WIN_SCORE / 2)) ? PSW'(TICK_DIV / 2 - 1) : PSW'(TICK_DIV - 1);
`else
  assign term = PSW'(TICK_DIV - 1);
`endif

  assign playing   = (presente == PLAY_STATE);
  assign tick      = (state == RUN) && (prescaler == term);
  assign jreq      = keypad_pressed && !key_q && (key == JUMP_KEY);
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      W_or_L    <= 2'b00;
      var_h     <= 2'b00;
      tipo_obs  <= 4'd0;
      obs_pos   <= TOP;
      score     <= 5'd0;
      jump_cnt  <= '0;
      prescaler <= '0;
      lfsr      <= 8'hA5;
      key_q     <= 1'b0;
    end else begin
      key_q <= keypad_pressed;
      case (state)
        IDLE: begin
          prescaler <= '0;
          jump_cnt  <= '0;
          W_or_L    <= 2'b00;
          var_h     <= 2'b00;
          if (playing) begin
            state    <= RUN;
            obs_pos  <= TOP;
            score    <= 5'd0;
            tipo_obs <= lfsr[3:0];
          end
        end
        RUN: begin
          if (!playing) begin
            state     <= IDLE;
            var_h     <= 2'b00;
            jump_cnt  <= '0;
            prescaler <= '0;
          end else if (tick) begin
            prescaler <= '0;
            lfsr      <= lfsr_next;
            // The tick is judged on this cycle's jump_cnt; a same-cycle press only
            // starts a jump afterwards if the hero survives.
            if (jump_cnt != '0) begin
              jump_cnt <= jump_cnt - 1'b1;
              if (jump_cnt == JW'(1)) var_h <= 2'b00;
            end else if (jreq && obs_pos != '0) begin
              jump_cnt <= JT;
              var_h    <= 2'b01;
            end
            if (obs_pos != '0) begin
              obs_pos <= obs_pos - 1'b1;
            end else if (jump_cnt != '0) begin
              score    <= score + 5'd1;
              obs_pos  <= TOP;
              tipo_obs <= lfsr[3:0];
              if (score + 5'd1 == 5'(WIN_SCORE)) begin
                state  <= WON;
                W_or_L <= 2'b01;
                var_h  <= 2'b00;
              end
            end else begin
              state  <= LOST;
              W_or_L <= 2'b10;
              var_h  <= 2'b00;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
            if (jreq && jump_cnt == '0) begin
              jump_cnt <= JT;
              var_h    <= 2'b01;
            end
          end
        end
        WON, LOST: begin
          prescaler <= '0;
          var_h     <= 2'b00;
          if (!playing) begin
            state  <= IDLE;
            W_or_L <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
